uio_pair_decoder: RTL
=====================

Name: uio_pair_decoder

Overview:
- Receive end of the 6-bit paired-flop bus that the register tile drives onto uio[5:0] when its output-enable is high.
- The bus carries {~q1^~q2, ~q2, ~q1, q1^q2, q2, q1} on bits 5..0.
- Samples the bus, checks the redundant encoding, applies a stability filter, and presents the decoded 2-bit value with valid, change and error indications.
- Sits on the consuming tile, fed directly from uio_in[5:0].

Parameters:
- STABLE_CYCLES, 3, consecutive identical legal samples required before acceptance; range 1..15.
- ERR_W, 4, width of the saturating error counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- ena  in  1  sample enable; when 0, the block holds all state.
- code_in  in  6  encoded bus from the remote uio[5:0].
- clear_err  in  1  synchronous clear of err_count.
- data_out  out  2  accepted value {q2,q1}.
- data_valid  out  1  high once any value has been accepted since reset.
- changed  out  1  one-cycle pulse when data_out is loaded.
- code_err  out  1  one-cycle pulse for each illegal sample taken.
- err_count  out  ERR_W  saturating count of illegal samples.

Behaviour:
- Legal codes, bits 5..0, are the only accepted values:
  - 6'h18 -> value 0
  - 6'h35 -> value 1
  - 6'h2E -> value 2
  - 6'h03 -> value 3
- All other 60 codes are illegal. Legality rule: c3==~c0, c4==~c1, c2==c0^c1, c5==c3^c4. Decoded value = {c1,c0}.
- Reset (rst_n low at an edge):
  - data_out=0, data_valid=0, changed=0, code_err=0, err_count=0.
  - Internal cand=0, run=0.
  - Reset overrides every other input, including mid-filter.
- State: UNLOCKED (data_valid=0) and LOCKED (data_valid=1). UNLOCKED -> LOCKED on first acceptance. LOCKED is left only by reset.
- Each edge with ena=1, legal sample of value v:
  - If v != cand: cand<=v, run<=1.
  - Else: run<=min(run+1, STABLE_CYCLES).
- Acceptance: at the edge where run_next==STABLE_CYCLES, and either (data_valid==0) or (cand_next != data_out):
  - data_out<=cand_next, data_valid<=1.
  - changed=1 for the following cycle only.
  - Re-reaching STABLE_CYCLES with the value already on data_out does not pulse changed.
- Latency: a code presented before edge 1 and held appears on data_out after edge STABLE_CYCLES. With STABLE_CYCLES=1, it appears after edge 1.
- Each edge with ena=1, illegal sample:
  - code_err=1 for the following cycle.
  - err_count<=err_count+1, saturating at all-ones (no wrap).
  - run<=0; cand, data_out and data_valid hold.
  - The next legal sample restarts the run at 1, even if it equals cand.
- ena=0: cand, run, data_out, data_valid and err_count hold. changed and code_err are 0 after that edge.
- clear_err=1: err_count<=0, independent of ena. Simultaneous with an illegal sample: err_count<=1 and code_err still pulses.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package holds:
  - constants CODE_V0=6'h18, CODE_V1=6'h35, CODE_V2=6'h2E, CODE_V3=6'h03;
  - code width 6 and value width 2;
  - the state enum {UNLOCKED, LOCKED}.
- One combinational sub-module, uio_pair_code_check: input code[5:0]; outputs legal and value[1:0]. It is reused by the verification model.
- Filter, counters and output registers live in the top.

Test Plan:
- Reset then hold 6'h35 with ena=1 for 3 edges -> data_out=1, data_valid=1 after edge 3; changed high exactly one cycle; code_err never high.
- Locked at 1, apply 6'h2E for 2 edges, then 6'h35 -> data_out stays 1, changed stays 0. Then hold 6'h2E 3 edges -> data_out=2 and one changed pulse.
- Locked at 2, apply 6'h00 for one edge between two 6'h2E runs -> code_err one pulse, err_count=1, data_out=2 held, no changed pulse.
- 20 consecutive illegal samples (6'h3F) -> err_count=15, no wrap. Then clear_err together with one illegal sample -> err_count=1.
- Hold 6'h03 with ena=0 for 5 edges -> no state change. Raise ena -> data_valid after 3 more edges.
- rst_n low for one edge after 2 of 3 matching samples -> all outputs 0. A fresh 3-edge run is required afterwards.

Source files
------------

// File: rtl/uio_pair_decoder_pkg.sv
// rtl/uio_pair_decoder_pkg.sv - shared constants and types for the uio pair decoder
// Purpose: legal paired-flop bus codes, field widths and lock-state enum.
// Ports: none (package).
package uio_pair_decoder_pkg;

  localparam int CODE_W = 6;
  localparam int VAL_W  = 2;
  localparam int RUN_W  = 4;

  localparam logic [CODE_W-1:0] CODE_V0 = 6'h18;
  localparam logic [CODE_W-1:0] CODE_V1 = 6'h35;
  localparam logic [CODE_W-1:0] CODE_V2 = 6'h2E;
  localparam logic [CODE_W-1:0] CODE_V3 = 6'h03;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/uio_pair_code_check.sv
// rtl/uio_pair_code_check.sv - legality check and decode of one paired-flop bus sample
// Purpose: combinational check of the redundant {~q1^~q2,~q2,~q1,q1^q2,q2,q1} encoding.
// Ports:
//   code  in  6  raw bus sample, bits 5..0
//   legal out 1  sample is one of the four legal codes
//   value out 2  decoded {q2,q1}; meaningful only when legal
module uio_pair_code_check
  import uio_pair_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic              legal,
  output logic [VAL_W-1:0]  value
);

  // Each redundant bit must agree with the two primary bits; together these
  // four equations admit exactly the four legal codes.
  always_comb begin
    legal = (code[3] == ~code[0]) &&
            (code[4] == ~code[1]) &&
            (code[2] == (code[0] ^ code[1])) &&
            (code[5] == (code[3] ^ code[4]));
    value = code[1:0];
  end

endmodule

// File: rtl/uio_pair_decoder.sv
// rtl/uio_pair_decoder.sv - receive-side decoder and stability filter for the uio pair bus
// Purpose: samples code_in, rejects illegal codes, requires STABLE_CYCLES identical
//          legal samples before loading data_out, and counts illegal samples.
// Ports:
//   clk        in   1      system clock
//   rst_n      in   1      synchronous active-low reset
//   ena        in   1      sample enable; 0 holds all state
//   code_in    in   6      encoded bus from remote uio[5:0]
//   clear_err  in   1      synchronous clear of err_count
//   data_out   out  2      accepted value {q2,q1}
//   data_valid out  1      a value has been accepted since reset
//   changed    out  1      one-cycle pulse when data_out is loaded
//   code_err   out  1      one-cycle pulse per illegal sample
//   err_count  out  ERR_W  saturating illegal-sample count
module uio_pair_decoder
  import uio_pair_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 3,
  parameter int ERR_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [CODE_W-1:0] code_in,
  input  logic              clear_err,
  output logic [VAL_W-1:0]  data_out,
  output logic              data_valid,
  output logic              changed,
  output logic              code_err,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  logic              chk_legal;
  logic [VAL_W-1:0]  chk_value;

  lock_state_e       state_q, state_d;
  logic [VAL_W-1:0]  cand_q, cand_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [VAL_W-1:0]  data_q, data_d;
  logic              changed_q, changed_d;
  logic              code_err_q, code_err_d;
  logic [ERR_W-1:0]  err_q, err_d;

  uio_pair_code_check u_check (
    .code  (code_in),
    .legal (chk_legal),
    .value (chk_value)
  );

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    run_d      = run_q;
    data_d     = data_q;
    changed_d  = 1'b0;
    code_err_d = 1'b0;
    err_d      = err_q;

    if (ena) begin
      if (chk_legal) begin
        if (chk_value != cand_q) begin
          cand_d = chk_value;
          run_d  = RUN_W'(1);
        end else if (run_q < RUN_MAX) begin
          // run_q is 0 after an illegal sample, so this also restarts at 1
          run_d = run_q + RUN_W'(1);
        end
        // Saturated run on the value already shown must not re-pulse changed.
        if ((run_d == RUN_MAX) && ((state_q == UNLOCKED) || (cand_d != data_q))) begin
          data_d    = cand_d;
          state_d   = LOCKED;
          changed_d = 1'b1;
        end
      end else begin
        code_err_d = 1'b1;
        run_d      = '0;
        if (err_q != {ERR_W{1'b1}}) begin
          err_d = err_q + ERR_W'(1);
        end
      end
    end

    // Clear wins over the old count but still records a coincident illegal sample.
    if (clear_err) begin
      err_d = (ena && !chk_legal) ? ERR_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= UNLOCKED;
      cand_q     <= '0;
      run_q      <= '0;
      data_q     <= '0;
      changed_q  <= 1'b0;
      code_err_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      run_q      <= run_d;
      data_q     <= data_d;
      changed_q  <= changed_d;
      code_err_q <= code_err_d;
      err_q      <= err_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = (state_q == LOCKED);
  assign changed    = changed_q;
  assign code_err   = code_err_q;
  assign err_count  = err_q;

endmodule
